video_tile_fill_dma: RTL and testbench

- Bus-initiator engine that fills a rectangle of the 64x32 tile/colour map with a 12-bit tile word. It removes per-tile CPU stores for screen clears, text-window blanking and scrolling seams.
- Toward the CPU it is an iomem responder with three config registers.
- Toward the video peripheral it is a write initiator that drives the same iomem-style signals the CPU would use.
- An optional mode defers the start to the next vsync so fills land during blanking.

---
 rtl/video_pkg.sv | 22 ++
 rtl/video_rect_walker.sv | 40 ++++
 rtl/video_tile_fill_dma.sv | 134 +++++++++++++
 tb/tb_video_tile_fill_dma.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared constants, register map, CTRL bit positions and FSM encoding
// for the tile/colour map fill engine.
package video_pkg;
    localparam logic [31:0] VIDEO_BASE_DEF = 32'h0500_0000;
    localparam logic [3:0]  TILEMAP_REGION = 4'h2;
    localparam int MAP_W = 64;
    localparam int MAP_H = 32;
    localparam int XW = $clog2(MAP_W);
    localparam int YW = $clog2(MAP_H);
    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_RECT  = 2'd1;
    localparam logic [1:0] REG_VALUE = 2'd2;
    localparam int CTRL_START = 0;
    localparam int CTRL_WVS   = 1;
    localparam int CTRL_INC   = 2;
    localparam int CTRL_ABORT = 3;
    typedef enum logic [2:0] {S_IDLE, S_WAIT_VS, S_ISSUE, S_ADVANCE, S_FINISH} state_t;
    function automatic logic [31:0] tile_addr(input logic [31:0] base, input logic [YW-1:0] yt,
                                              input logic [XW-1:0] xt);
        return base | {8'h00, TILEMAP_REGION, 20'h0} | {{(32-YW-XW-2){1'b0}}, yt, xt, 2'b00};
    endfunction
endpackage

// File: rtl/video_rect_walker.sv
// video_rect_walker: column/row walk over a rectangle that wraps at the map edges,
// producing the current tile byte address and a last-tile flag.
module video_rect_walker
    import video_pkg::*;
#(
    parameter logic [31:0] VIDEO_BASE = VIDEO_BASE_DEF
)(
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          step,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w_m1,
    input  logic [YW-1:0] h_m1,
    output logic [31:0]   addr,
    output logic          last
);
    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic [XW-1:0] xt;
    logic [YW-1:0] yt;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (step) begin
            col <= (col == w_m1) ? '0 : col + 1'b1;
            row <= (col == w_m1) ? row + 1'b1 : row;
        end
    end
    // Modular adds give the wrap-around at the right and bottom map edges.
    assign xt   = XW'(x0 + col);
    assign yt   = YW'(y0 + row);
    assign last = (col == w_m1) && (row == h_m1);
    assign addr = tile_addr(VIDEO_BASE, yt, xt);
endmodule

// File: rtl/video_tile_fill_dma.sv
// video_tile_fill_dma: CPU-programmed engine that writes one tile word into every
// cell of a rectangle of the tile/colour map, optionally starting at vsync.
module video_tile_fill_dma
    import video_pkg::*;
#(
    parameter logic [31:0] VIDEO_BASE = VIDEO_BASE_DEF,
    parameter bit          INC_EN     = 1'b1
)(
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        vid_valid,
    input  logic        vid_ready,
    output logic [31:0] vid_addr,
    output logic [3:0]  vid_wstrb,
    output logic [31:0] vid_wdata,
    input  logic        vga_vsync,
    output logic        done_irq
);
    state_t        state, state_nx;
    logic          served, acc, wr, cfg_wr, ctrl_wr;
    logic [1:0]    reg_sel;
    logic [XW-1:0] x0, w_m1;
    logic [YW-1:0] y0, h_m1;
    logic [11:0]   value;
    logic          wvs, inc, done, abort_pend, vs_q;
    logic          busy, start_now, abort_now, abort_any, vs_fall, last, step;
    logic [31:0]   walk_addr, rd_data;
    logic          unused_bits;
    assign reg_sel   = iomem_addr[3:2];
    assign acc       = iomem_valid && !iomem_ready && !served;
    assign wr        = acc && (iomem_wstrb != 4'b0000);
    assign busy      = (state == S_WAIT_VS) || (state == S_ISSUE) || (state == S_ADVANCE);
    assign cfg_wr    = wr && !busy;
    assign ctrl_wr   = wr && (reg_sel == REG_CTRL) && iomem_wstrb[0];
    assign start_now = ctrl_wr && iomem_wdata[CTRL_START] && (state == S_IDLE);
    assign abort_now = ctrl_wr && iomem_wdata[CTRL_ABORT] && busy;
    assign abort_any = abort_now || abort_pend;
    assign vs_fall   = vs_q && !vga_vsync;
    assign step      = (state == S_ADVANCE);
    assign rd_data   = (reg_sel == REG_CTRL)  ? {22'b0, done, busy, 4'b0, inc, wvs, 2'b0} :
                       (reg_sel == REG_RECT)  ? {3'b0, h_m1, 2'b0, w_m1, 3'b0, y0, 2'b0, x0} :
                       (reg_sel == REG_VALUE) ? {20'b0, value} : 32'h0;
    assign unused_bits = &{1'b0, iomem_addr[31:4], iomem_addr[1:0], iomem_wdata[31:29],
                           iomem_wdata[23:22], iomem_wdata[15:13]};
    // One ready pulse per valid assertion; served blocks re-acks until valid drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
            served      <= 1'b0;
        end else begin
            iomem_ready <= acc;
            iomem_rdata <= (acc && iomem_wstrb == 4'b0000) ? rd_data : '0;
            served      <= iomem_valid && (served || iomem_ready);
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x0    <= '0;
            y0    <= '0;
            w_m1  <= '0;
            h_m1  <= '0;
            value <= '0;
        end else begin
            if (cfg_wr && reg_sel == REG_RECT) begin
                if (iomem_wstrb[0]) x0   <= iomem_wdata[5:0];
                if (iomem_wstrb[1]) y0   <= iomem_wdata[12:8];
                if (iomem_wstrb[2]) w_m1 <= iomem_wdata[21:16];
                if (iomem_wstrb[3]) h_m1 <= iomem_wdata[28:24];
            end
            if (step && inc) begin
                value <= value + 12'd1;
            end else if (cfg_wr && reg_sel == REG_VALUE) begin
                if (iomem_wstrb[0]) value[7:0]  <= iomem_wdata[7:0];
                if (iomem_wstrb[1]) value[11:8] <= iomem_wdata[11:8];
            end
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wvs        <= 1'b0;
            inc        <= 1'b0;
            done       <= 1'b0;
            abort_pend <= 1'b0;
            vs_q       <= 1'b1;
        end else begin
            if (start_now) begin
                wvs <= iomem_wdata[CTRL_WVS];
                inc <= INC_EN && iomem_wdata[CTRL_INC];
            end
            done       <= start_now ? 1'b0 : (done || state == S_FINISH);
            abort_pend <= (state == S_FINISH) ? 1'b0 : abort_any;
            vs_q       <= vga_vsync;
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end
    always_comb begin
        state_nx  = state;
        vid_valid = (state == S_ISSUE);
        vid_addr  = vid_valid ? walk_addr : 32'h0;
        vid_wstrb = vid_valid ? 4'b0011 : 4'b0000;
        vid_wdata = vid_valid ? {20'b0, value} : 32'h0;
        done_irq  = (state == S_FINISH);
        case (state)
            S_IDLE:    if (start_now) state_nx = iomem_wdata[CTRL_WVS] ? S_WAIT_VS : S_ISSUE;
            S_WAIT_VS: state_nx = abort_any ? S_FINISH : (vs_fall ? S_ISSUE : S_WAIT_VS);
            S_ISSUE:   if (vid_ready) state_nx = S_ADVANCE;
            S_ADVANCE: state_nx = (abort_any || last) ? S_FINISH : S_ISSUE;
            S_FINISH:  state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end
    video_rect_walker #(.VIDEO_BASE(VIDEO_BASE)) u_walker (
        .clk    (clk),
        .resetn (resetn),
        .clear  (start_now),
        .step   (step),
        .x0     (x0),
        .y0     (y0),
        .w_m1   (w_m1),
        .h_m1   (h_m1),
        .addr   (walk_addr),
        .last   (last)
    );
endmodule

// File: tb/tb_video_tile_fill_dma.sv
// tb_video_tile_fill_dma: directed checks of register access, fill order, wrap,
// increment, vsync deferral, stall with abort and mid-fill reset.
module tb_video_tile_fill_dma;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = 4'h0;
    logic [31:0] iomem_addr = 32'h0;
    logic [31:0] iomem_wdata = 32'h0;
    logic [31:0] iomem_rdata;
    logic        vid_valid;
    logic        vid_ready = 1'b1;
    logic [31:0] vid_addr;
    logic [3:0]  vid_wstrb;
    logic [31:0] vid_wdata;
    logic        vga_vsync = 1'b1;
    logic        done_irq;
    int n_checks = 0;
    int n_fail = 0;
    int irq_cnt = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [3:0]  wr_strb[$];

    video_tile_fill_dma dut (
        .clk(clk), .resetn(resetn), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .vid_valid(vid_valid), .vid_ready(vid_ready),
        .vid_addr(vid_addr), .vid_wstrb(vid_wstrb), .vid_wdata(vid_wdata),
        .vga_vsync(vga_vsync), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    // Inputs only change just after posedge, so negedge shows what the next edge captures.
    always @(negedge clk) begin
        if (vid_valid && vid_ready) begin
            wr_addr.push_back(vid_addr);
            wr_data.push_back(vid_wdata);
            wr_strb.push_back(vid_wstrb);
        end
        if (done_irq) irq_cnt++;
    end

    task automatic cpu_access(input logic [3:0] off, input logic [31:0] d, input logic [3:0] s,
                              output logic [31:0] r);
        int n;
        n = 0;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000 | {28'h0, off};
        iomem_wdata = d;
        iomem_wstrb = s;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!iomem_ready && n < 8);
        r = iomem_rdata;
        n_checks++;
        if (!iomem_ready) begin
            n_fail++;
            $display("FAIL iomem_ready_timeout: ready=%b after %0d cycles, required 1", iomem_ready, n);
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_strb.delete();
    endtask

    task automatic test_reset();
        logic [31:0] r;
        int pulses;
        #1;
        n_checks++; if (vid_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_vid_valid: got %b want 0", vid_valid); end
        n_checks++; if (vid_addr !== 32'h0)   begin n_fail++; $display("FAIL rst_vid_addr: got %h want 0", vid_addr); end
        n_checks++; if (vid_wstrb !== 4'h0)   begin n_fail++; $display("FAIL rst_vid_wstrb: got %h want 0", vid_wstrb); end
        n_checks++; if (vid_wdata !== 32'h0)  begin n_fail++; $display("FAIL rst_vid_wdata: got %h want 0", vid_wdata); end
        n_checks++; if (done_irq !== 1'b0)    begin n_fail++; $display("FAIL rst_done_irq: got %b want 0", done_irq); end
        n_checks++; if (iomem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_iomem_ready: got %b want 0", iomem_ready); end
        n_checks++; if (iomem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_iomem_rdata: got %h want 0", iomem_rdata); end
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        cpu_access(4'h0, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rst_ctrl_read: got %h want 0", r); end
        cpu_access(4'h4, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rst_rect_read: got %h want 0", r); end
        cpu_access(4'h8, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rst_value_read: got %h want 0", r); end
        cpu_access(4'hC, 32'hFFFF_FFFF, 4'hF, r);
        cpu_access(4'hC, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL reserved_read: got %h want 0", r); end
        // Byte strobes: only byte 1 of RECT written, so only y0 changes.
        cpu_access(4'h4, 32'h1F3F_1F3F, 4'h2, r);
        cpu_access(4'h4, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0000_1F00) begin n_fail++; $display("FAIL rect_byte_strobe: got %h want 00001f00", r); end
        // Held valid must yield exactly one ready pulse.
        pulses = 0;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        iomem_wstrb = 4'h0;
        repeat (5) begin
            @(posedge clk); #1;
            if (iomem_ready) pulses++;
        end
        iomem_valid = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL ready_single_pulse: got %0d pulses want 1", pulses); end
    endtask

    task automatic test_basic_fill();
        logic [31:0] r;
        logic [31:0] exp_a[4];
        int i0;
        exp_a = '{32'h0520_0308, 32'h0520_030C, 32'h0520_0408, 32'h0520_040C};
        vid_ready = 1'b1;
        cpu_access(4'h8, 32'h0000_0123, 4'hF, r);
        cpu_access(4'h4, 32'h0101_0302, 4'hF, r);
        clear_log();
        i0 = irq_cnt;
        cpu_access(4'h0, 32'h0000_0001, 4'hF, r);
        for (int i = 0; i < 200 && irq_cnt == i0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (irq_cnt != i0 + 1) begin n_fail++; $display("FAIL basic_irq_count: got %0d want 1", irq_cnt - i0); end
        n_checks++; if (wr_addr.size() != 4) begin n_fail++; $display("FAIL basic_write_count: got %0d want 4", wr_addr.size()); end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ga, gd;
            logic [3:0] gs;
            ga = (i < wr_addr.size()) ? wr_addr[i] : 32'hx;
            gd = (i < wr_data.size()) ? wr_data[i] : 32'hx;
            gs = (i < wr_strb.size()) ? wr_strb[i] : 4'hx;
            n_checks++; if (ga !== exp_a[i]) begin n_fail++; $display("FAIL basic_addr[%0d]: got %h want %h", i, ga, exp_a[i]); end
            n_checks++; if (gd !== 32'h123) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want 00000123", i, gd); end
            n_checks++; if (gs !== 4'b0011) begin n_fail++; $display("FAIL basic_wstrb[%0d]: got %b want 0011", i, gs); end
        end
        cpu_access(4'h0, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0000_0200) begin n_fail++; $display("FAIL basic_ctrl_status: got %h want 00000200", r); end
    endtask

    task automatic test_wrap();
        logic [31:0] r, e, g;
        int xs[8];
        int ys[8];
        int i0;
        xs = '{62, 63, 0, 1, 62, 63, 0, 1};
        ys = '{31, 31, 31, 31, 0, 0, 0, 0};
        cpu_access(4'h8, 32'h0000_0055, 4'hF, r);
        cpu_access(4'h4, 32'h0103_1F3E, 4'hF, r);
        clear_log();
        i0 = irq_cnt;
        cpu_access(4'h0, 32'h0000_0001, 4'hF, r);
        for (int i = 0; i < 200 && irq_cnt == i0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (wr_addr.size() != 8) begin n_fail++; $display("FAIL wrap_write_count: got %0d want 8", wr_addr.size()); end
        for (int i = 0; i < 8; i++) begin
            e = 32'h0520_0000 | 32'(ys[i] << 8) | 32'(xs[i] << 2);
            g = (i < wr_addr.size()) ? wr_addr[i] : 32'hx;
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, g, e); end
        end
    endtask

    task automatic test_increment();
        logic [31:0] r, g;
        logic [31:0] exp_d[4];
        int i0;
        exp_d = '{32'hFFE, 32'hFFF, 32'h000, 32'h001};
        cpu_access(4'h8, 32'h0000_0FFE, 4'hF, r);
        cpu_access(4'h4, 32'h0003_0000, 4'hF, r);
        clear_log();
        i0 = irq_cnt;
        cpu_access(4'h0, 32'h0000_0005, 4'hF, r);
        for (int i = 0; i < 200 && irq_cnt == i0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (wr_data.size() != 4) begin n_fail++; $display("FAIL inc_write_count: got %0d want 4", wr_data.size()); end
        for (int i = 0; i < 4; i++) begin
            g = (i < wr_data.size()) ? wr_data[i] : 32'hx;
            n_checks++; if (g !== exp_d[i]) begin n_fail++; $display("FAIL inc_data[%0d]: got %h want %h", i, g, exp_d[i]); end
        end
        cpu_access(4'h8, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0000_0002) begin n_fail++; $display("FAIL inc_value_after: got %h want 00000002", r); end
        cpu_access(4'h0, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0000_0208) begin n_fail++; $display("FAIL inc_ctrl_status: got %h want 00000208", r); end
    endtask

    task automatic test_vsync();
        logic [31:0] r, g;
        int i0;
        int lat;
        vga_vsync = 1'b0;
        cpu_access(4'h8, 32'h0000_00C3, 4'hF, r);
        cpu_access(4'h4, 32'h0000_0105, 4'hF, r);
        clear_log();
        i0 = irq_cnt;
        cpu_access(4'h0, 32'h0000_0003, 4'hF, r);
        repeat (8) @(posedge clk);
        #1;
        cpu_access(4'h0, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0000_0104) begin n_fail++; $display("FAIL vs_ctrl_busy: got %h want 00000104", r); end
        cpu_access(4'h8, 32'h0000_0777, 4'hF, r);
        cpu_access(4'h8, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0000_00C3) begin n_fail++; $display("FAIL vs_value_locked: got %h want 000000c3", r); end
        vga_vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (wr_addr.size() != 0 || vid_valid !== 1'b0) begin
            n_fail++; $display("FAIL vs_no_early_write: writes=%0d vid_valid=%b want 0/0", wr_addr.size(), vid_valid);
        end
        vga_vsync = 1'b0;
        lat = 0;
        for (int i = 1; i <= 2 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (vid_valid) lat = i;
        end
        n_checks++; if (lat == 0) begin n_fail++; $display("FAIL vs_first_write_latency: vid_valid not seen within 2 cycles, want within 2"); end
        for (int i = 0; i < 50 && irq_cnt == i0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        g = (wr_addr.size() > 0) ? wr_addr[0] : 32'hx;
        n_checks++; if (wr_addr.size() != 1) begin n_fail++; $display("FAIL vs_write_count: got %0d want 1", wr_addr.size()); end
        n_checks++; if (g !== 32'h0520_0114) begin n_fail++; $display("FAIL vs_addr: got %h want 05200114", g); end
        g = (wr_data.size() > 0) ? wr_data[0] : 32'hx;
        n_checks++; if (g !== 32'h0000_00C3) begin n_fail++; $display("FAIL vs_data: got %h want 000000c3", g); end
        vga_vsync = 1'b1;
    endtask

    task automatic test_stall_abort();
        logic [31:0] r, a0, d0;
        int i0;
        int bad;
        cpu_access(4'h8, 32'h0000_00AB, 4'hF, r);
        cpu_access(4'h4, 32'h0101_0000, 4'hF, r);
        vid_ready = 1'b0;
        clear_log();
        i0 = irq_cnt;
        cpu_access(4'h0, 32'h0000_0001, 4'hF, r);
        for (int i = 0; i < 10 && !vid_valid; i++) begin @(posedge clk); #1; end
        n_checks++; if (vid_valid !== 1'b1) begin n_fail++; $display("FAIL stall_request_seen: vid_valid=%b want 1", vid_valid); end
        a0 = vid_addr;
        d0 = vid_wdata;
        n_checks++; if (a0 !== 32'h0520_0000) begin n_fail++; $display("FAIL stall_addr: got %h want 05200000", a0); end
        bad = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (!vid_valid || vid_addr !== a0 || vid_wdata !== d0 || vid_wstrb !== 4'b0011) bad++;
        end
        cpu_access(4'h0, 32'h0000_0008, 4'hF, r);
        if (!vid_valid || vid_addr !== a0 || vid_wdata !== d0 || vid_wstrb !== 4'b0011) bad++;
        @(posedge clk); #1;
        if (!vid_valid || vid_addr !== a0 || vid_wdata !== d0 || vid_wstrb !== 4'b0011) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold_stable: %0d unstable samples, want 0", bad); end
        vid_ready = 1'b1;
        for (int i = 0; i < 50 && irq_cnt == i0; i++) @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (wr_addr.size() != 1) begin n_fail++; $display("FAIL abort_write_count: got %0d want 1", wr_addr.size()); end
        n_checks++; if (irq_cnt != i0 + 1) begin n_fail++; $display("FAIL abort_irq_count: got %0d want 1", irq_cnt - i0); end
        cpu_access(4'h0, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0000_0200) begin n_fail++; $display("FAIL abort_ctrl_status: got %h want 00000200", r); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] r;
        cpu_access(4'h4, 32'h1F3F_0000, 4'hF, r);
        vid_ready = 1'b0;
        cpu_access(4'h0, 32'h0000_0001, 4'hF, r);
        for (int i = 0; i < 10 && !vid_valid; i++) begin @(posedge clk); #1; end
        n_checks++; if (vid_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_request_seen: vid_valid=%b want 1", vid_valid); end
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        n_checks++; if (vid_valid !== 1'b0 || vid_addr !== 32'h0) begin
            n_fail++; $display("FAIL midrst_drop: vid_valid=%b vid_addr=%h want 0/0", vid_valid, vid_addr);
        end
        vid_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        clear_log();
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (wr_addr.size() != 0) begin n_fail++; $display("FAIL midrst_no_writes: got %0d want 0", wr_addr.size()); end
        cpu_access(4'h0, 32'h0, 4'h0, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL midrst_ctrl_read: got %h want 0", r); end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_wrap();
        test_increment();
        test_vsync();
        test_stall_abort();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
